// File: rtl/sirena_pkg.sv
// Shared state codes and width for the siren controller, its board top and its testbench.
package sirena_pkg;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    IDLE     = 2'd0,
    RETARDO  = 2'd1,
    SONANDO  = 2'd2,
    SILENCIO = 2'd3
  } estado_t;

endpackage

// File: rtl/sirena_timer.sv
// Prescaler plus tick counter; clr restarts both so every state dwell is an exact multiple of PRESCALE.
module sirena_timer #(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] presc_r;
  logic [CNT_W-1:0] count_r;

  assign tick  = (presc_r == PRESC_LAST);
  assign count = count_r;

  // Prescaler and tick counter; the tick counter saturates so a long idle dwell cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {CNT_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      presc_r <= {CNT_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      presc_r <= {CNT_W{1'b0}};
      if (count_r != {CNT_W{1'b1}}) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end else begin
      presc_r <= presc_r + CNT_W'(1);
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/sirena_ctrl.sv
// Alarm siren controller: entry delay, bounded pulsed siren, silent latched state until disarm.
// Optional alarm-memory indicator on luz is built only when SIRENA_MEMORIA_EN is defined.
module sirena_ctrl
  import sirena_pkg::*;
#(
  parameter int PRESCALE    = 100000,
  parameter int ENTRY_TICKS = 10000,
  parameter int ALARM_TICKS = 60000,
  parameter int HALF_PERIOD = 250,
  parameter int CNT_W       = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                A,
  input  logic                Bocina,
  input  logic                Pa,
  output logic                sirena,
  output logic [ESTADO_W-1:0] estado,
  output logic                luz
);

  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_TICKS - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);

  // Bit order in the synchroniser vectors: {A, Bocina, Pa}
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic             pa_prev_r;
  logic             a_s;
  logic             bocina_s;
  logic             pa_s;
  logic             pa_rise_s;
  estado_t          state_r;
  estado_t          state_next_s;
  logic             clr_s;
  logic             tick_s;
  logic [CNT_W-1:0] count_s;
  logic             sirena_r;
  logic [CNT_W-1:0] half_cnt_r;

  assign a_s       = sync2_r[2];
  assign bocina_s  = sync2_r[1];
  assign pa_s      = sync2_r[0];
  assign pa_rise_s = pa_s & ~pa_prev_r;
  assign clr_s     = (state_next_s != state_r);

  // Two-flop synchronisers for the asynchronous inputs, plus the Pa edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 3'b000;
      sync2_r   <= 3'b000;
      pa_prev_r <= 1'b0;
    end else begin
      sync1_r   <= {A, Bocina, Pa};
      sync2_r   <= sync1_r;
      pa_prev_r <= sync2_r[0];
    end
  end

  sirena_timer #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s),
    .count (count_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: disarm beats panic beats timeout beats sensor request, except a held Pa keeps SONANDO.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pa_s) begin
          state_next_s = SONANDO;
        end else if (a_s && bocina_s) begin
          state_next_s = RETARDO;
        end else begin
          state_next_s = IDLE;
        end
      end
      RETARDO: begin
        if (!a_s) begin
          state_next_s = IDLE;
        end else if (pa_s) begin
          state_next_s = SONANDO;
        end else if (tick_s && (count_s == ENTRY_LAST)) begin
          state_next_s = SONANDO;
        end else begin
          state_next_s = RETARDO;
        end
      end
      SONANDO: begin
        if (!a_s && !pa_s) begin
          state_next_s = IDLE;
        end else if (tick_s && (count_s == ALARM_LAST)) begin
          state_next_s = SILENCIO;
        end else begin
          state_next_s = SONANDO;
        end
      end
      SILENCIO: begin
        if (!a_s) begin
          state_next_s = IDLE;
        end else if (pa_rise_s) begin
          state_next_s = SONANDO;
        end else begin
          state_next_s = SILENCIO;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Siren drive: starts high on entry to SONANDO and flips every HALF_PERIOD ticks; low elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sirena_r   <= 1'b0;
      half_cnt_r <= {CNT_W{1'b0}};
    end else if (state_next_s != SONANDO) begin
      sirena_r   <= 1'b0;
      half_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != SONANDO) begin
      sirena_r   <= 1'b1;
      half_cnt_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      if (half_cnt_r == HALF_LAST) begin
        sirena_r   <= ~sirena_r;
        half_cnt_r <= {CNT_W{1'b0}};
      end else begin
        sirena_r   <= sirena_r;
        half_cnt_r <= half_cnt_r + CNT_W'(1);
      end
    end else begin
      sirena_r   <= sirena_r;
      half_cnt_r <= half_cnt_r;
    end
  end

  assign sirena = sirena_r;
  assign estado = state_r;

`ifdef SIRENA_MEMORIA_EN
  logic luz_r;

  // Alarm memory: set on any entry to SONANDO, cleared only when a fresh delayed event starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luz_r <= 1'b0;
    end else if ((state_next_s == SONANDO) && (state_r != SONANDO)) begin
      luz_r <= 1'b1;
    end else if ((state_r == IDLE) && (state_next_s == RETARDO)) begin
      luz_r <= 1'b0;
    end else begin
      luz_r <= luz_r;
    end
  end

  assign luz = luz_r;
`else
  assign luz = 1'b0;
`endif

endmodule

// File: tb/tb_sirena_ctrl.sv
// Directed self-checking bench for sirena_ctrl with small timing parameters.
module tb_sirena_ctrl;
  import sirena_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       A;
  logic       Bocina;
  logic       Pa;
  logic       sirena;
  logic [1:0] estado;
  logic       luz;

  int n_checks;
  int n_errors;

`ifdef SIRENA_MEMORIA_EN
  localparam logic LUZ_MEM = 1'b1;
`else
  localparam logic LUZ_MEM = 1'b0;
`endif

  sirena_ctrl #(
    .PRESCALE    (4),
    .ENTRY_TICKS (3),
    .ALARM_TICKS (8),
    .HALF_PERIOD (2),
    .CNT_W       (17)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .Bocina (Bocina),
    .Pa     (Pa),
    .sirena (sirena),
    .estado (estado),
    .luz    (luz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n cycles, landing on the falling edge where inputs are driven and outputs sampled.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Check a full SONANDO dwell: 8 high, 8 low, repeating, then SILENCIO at cycle 32.
  task automatic check_sounding(input string tag);
    for (int i = 0; i < 32; i++) begin
      check({tag, "_state"}, 32'(estado), 32'(SONANDO));
      check({tag, "_sirena"}, 32'(sirena), 32'(((i / 8) % 2) == 0));
      cycles(1);
    end
    check({tag, "_end_state"}, 32'(estado), 32'(SILENCIO));
    check({tag, "_end_sirena"}, 32'(sirena), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    A = 1'b0; Bocina = 1'b0; Pa = 1'b0;
    rst_n = 1'b0;

    // 1. Reset held 50 cycles.
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      check("rst_out", {29'h0, estado, sirena, luz}, 32'h0);
    end
    rst_n = 1'b1;
    cycles(2);

    // 2. Armed sensor alarm: entry delay, sounding, silence.
    A = 1'b1; Bocina = 1'b1;
    cycles(2);
    check("t2_pre_idle", 32'(estado), 32'(IDLE));
    cycles(1);
    check("t2_retardo", 32'(estado), 32'(RETARDO));
    Bocina = 1'b0;
    for (int i = 1; i < 12; i++) begin
      cycles(1);
      check("t2_delay_state", 32'(estado), 32'(RETARDO));
      check("t2_delay_sirena", 32'(sirena), 32'h0);
    end
    cycles(1);
    check("t2_luz", 32'(luz), 32'(LUZ_MEM));
    check_sounding("t2");
    check("t2_sil_luz", 32'(luz), 32'(LUZ_MEM));

    // 5. Panic pulse in SILENCIO restarts a full sounding, then disarm.
    cycles(3);
    check("t5_silencio_hold", 32'(estado), 32'(SILENCIO));
    Pa = 1'b1;
    cycles(1);
    Pa = 1'b0;
    cycles(1);
    check("t5_pre", 32'(estado), 32'(SILENCIO));
    cycles(1);
    check_sounding("t5");
    A = 1'b0;
    cycles(2);
    check("t5_pre_idle", 32'(estado), 32'(SILENCIO));
    cycles(1);
    check("t5_idle", 32'(estado), 32'(IDLE));
    cycles(5);
    check("t5_luz_mem", 32'(luz), 32'(LUZ_MEM));

    // 3. Disarm 5 cycles into the entry delay; the new event clears luz.
    A = 1'b1; Bocina = 1'b1;
    cycles(3);
    check("t3_retardo", 32'(estado), 32'(RETARDO));
    check("t3_luz_clr", 32'(luz), 32'h0);
    cycles(5);
    A = 1'b0;
    cycles(2);
    check("t3_still_retardo", 32'(estado), 32'(RETARDO));
    cycles(1);
    check("t3_idle", 32'(estado), 32'(IDLE));
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check("t3_idle_hold", {29'h0, estado, sirena, luz}, 32'h0);
    end
    Bocina = 1'b0;

    // 4. Panic while disarmed, then release.
    Pa = 1'b1;
    cycles(2);
    check("t4_pre", 32'(estado), 32'(IDLE));
    cycles(1);
    check("t4_sonando", 32'(estado), 32'(SONANDO));
    check("t4_sirena", 32'(sirena), 32'h1);
    check("t4_luz", 32'(luz), 32'(LUZ_MEM));
    cycles(4);
    Pa = 1'b0;
    cycles(2);
    check("t4_held", 32'(estado), 32'(SONANDO));
    cycles(1);
    check("t4_idle", 32'(estado), 32'(IDLE));
    check("t4_idle_sirena", 32'(sirena), 32'h0);

    // 6. Asynchronous reset during sounding.
    Pa = 1'b1;
    cycles(3);
    check("t6_sonando", 32'(estado), 32'(SONANDO));
    check("t6_sirena_on", 32'(sirena), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_state", 32'(estado), 32'(IDLE));
    check("t6_async_sirena", 32'(sirena), 32'h0);
    check("t6_async_luz", 32'(luz), 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("t6_resample_idle", 32'(estado), 32'(IDLE));
    check("t6_resample_sirena", 32'(sirena), 32'h0);
    cycles(1);
    check("t6_resonando", 32'(estado), 32'(SONANDO));
    Pa = 1'b0;
    cycles(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
